// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet parser blocks.
package eth_parser_pkg;

  // Bytes of L2 header captured per frame (dst MAC, src MAC, ethertype).
  localparam int unsigned HDR_BYTES = 14;

  typedef logic [15:0] ethertype_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: step only when not already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/eth_header_capture.sv
// Captures the 14-byte Ethernet header of each frame, holds it for the
// downstream VLAN stage, discards the payload and counts good/runt frames.
module eth_header_capture
  import eth_parser_pkg::*;
#(
  parameter int unsigned HDR_BYTES = eth_parser_pkg::HDR_BYTES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  output logic [HDR_BYTES-1:0][7:0]  header_bytes,
  output ethertype_t                 ethertype_raw,
  output logic                       fields_valid,
  input  logic                       hdr_ready,
  output logic                       runt_err,
  output logic [CNT_W-1:0]           frame_count,
  output logic [CNT_W-1:0]           runt_count
);

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StHold,
    StSkip
  } state_e;

  localparam logic [3:0] LastIdx = 4'(HDR_BYTES - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 byte_cnt_q, byte_cnt_d;
  logic                       frame_ended_q, frame_ended_d;
  logic                       fields_valid_q, fields_valid_d;
  logic                       runt_err_q, runt_err_d;
  logic [HDR_BYTES-1:0][7:0]  hdr_q, hdr_d;
  logic                       accept;
  logic                       frame_inc;
  logic                       runt_inc;

  // Upstream is stalled only while a header waits for the consumer.
  assign s_tready = (state_q != StHold);
  assign accept   = s_tvalid && s_tready;

  // Next-state, header capture and counter strobes.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    frame_ended_d  = frame_ended_q;
    fields_valid_d = fields_valid_q;
    runt_err_d     = 1'b0;
    hdr_d          = hdr_q;
    frame_inc      = 1'b0;
    runt_inc       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_d[0] = s_tdata;
          if (s_tlast) begin
            // Single-byte frame: runt, stay idle.
            runt_err_d = 1'b1;
            runt_inc   = 1'b1;
            byte_cnt_d = 4'd0;
          end else begin
            byte_cnt_d = 4'd1;
            state_d    = StHdr;
          end
        end
      end
      StHdr: begin
        if (accept) begin
          hdr_d[byte_cnt_q] = s_tdata;
          if (byte_cnt_q == LastIdx) begin
            // Last header byte; a tlast here means there is no payload to skip.
            byte_cnt_d     = 4'd0;
            state_d        = StHold;
            fields_valid_d = 1'b1;
            frame_ended_d  = s_tlast;
          end else if (s_tlast) begin
            runt_err_d = 1'b1;
            runt_inc   = 1'b1;
            byte_cnt_d = 4'd0;
            state_d    = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      StHold: begin
        if (hdr_ready) begin
          fields_valid_d = 1'b0;
          frame_inc      = 1'b1;
          frame_ended_d  = 1'b0;
          state_d        = frame_ended_q ? StIdle : StSkip;
        end
      end
      StSkip: begin
        if (accept && s_tlast) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      byte_cnt_q     <= 4'd0;
      frame_ended_q  <= 1'b0;
      fields_valid_q <= 1'b0;
      runt_err_q     <= 1'b0;
      hdr_q          <= '0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      frame_ended_q  <= frame_ended_d;
      fields_valid_q <= fields_valid_d;
      runt_err_q     <= runt_err_d;
      hdr_q          <= hdr_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_inc),
    .count (frame_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_runt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (runt_inc),
    .count (runt_count)
  );

  assign header_bytes  = hdr_q;
  assign ethertype_raw = {hdr_q[12], hdr_q[13]};
  assign fields_valid  = fields_valid_q;
  assign runt_err      = runt_err_q;

endmodule
